// File: rtl/conv_frame_sequencer.sv
// Streams one IMG_W x IMG_H frame from the image buffer into the forward-pass datapath,
// then latches the datapath result. Optional WAIT timeout enabled by CONV_SEQ_TIMEOUT_EN.
module conv_frame_sequencer #(
    parameter int unsigned IMG_W    = 28,
    parameter int unsigned IMG_H    = 28,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned LINE_GAP = 2,
    parameter int unsigned OUT_W    = 160,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  result,
    output logic              timeout_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              frame_start,
    output logic              line_start,
    output logic              frame_end,
    output logic              ena,
    output logic [7:0]        ima,
    input  logic              fp_valid,
    input  logic [OUT_W-1:0]  fp_out
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    // Reject parameter sets the address bus or counters cannot represent.
    if ((64'(1) << ADDR_W) < 64'(IMG_W) * 64'(IMG_H) || IMG_W == 0 || IMG_H == 0 ||
        TIMEOUT == 0) begin : g_bad_cfg
        $error("conv_frame_sequencer: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic              r_ena;
    logic              r_frame_start;
    logic              r_line_start;
    logic              r_frame_end;
    logic              r_busy;
    logic              r_done;
    logic [OUT_W-1:0]  r_result;
`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0]   r_wait_cnt;
    logic              r_timeout_err;
`endif

    logic w_col_first;
    logic w_col_last;
    logic w_row_first;
    logic w_row_last;

    assign w_col_first = (r_col == '0);
    assign w_col_last  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_first = (r_row == '0);
    assign w_row_last  = (r_row == ROW_W'(IMG_H - 1));

    // Framing flags are registered at the read cycle so they line up with the returned pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_gap_cnt     <= '0;
            r_addr        <= '0;
            r_rd_en       <= 1'b0;
            r_ena         <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_end   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
`ifdef CONV_SEQ_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_rd_en       <= 1'b0;
            r_ena         <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_end   <= 1'b0;
            r_done        <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_addr  <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                S_READ: begin
                    r_ena         <= 1'b1;
                    r_line_start  <= w_col_first;
                    r_frame_start <= w_col_first && w_row_first;
                    r_frame_end   <= w_col_last && w_row_last;
                    r_addr        <= r_addr + ADDR_W'(1);
                    if (w_col_last) begin
                        r_col <= '0;
                        if (w_row_last) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                            if (LINE_GAP > 0) begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= '0;
                            end else begin
                                r_rd_en <= 1'b1;
                            end
                        end
                    end else begin
                        r_col   <= r_col + COL_W'(1);
                        r_rd_en <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(LINE_GAP - 1)) begin
                        r_state <= S_READ;
                        r_rd_en <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_state <= S_WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    // A result arriving on the final count still takes priority over the abort.
                    if (fp_valid) begin
                        r_result <= fp_out;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
`ifdef CONV_SEQ_TIMEOUT_EN
                    else if (r_wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_result      <= '0;
                        r_done        <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign mem_rd_en   = r_rd_en;
    assign mem_addr    = r_addr;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign frame_end   = r_frame_end;
    assign ena         = r_ena;
    // The buffer's read port is registered, so its data already lands in the ena cycle.
    assign ima         = r_ena ? mem_rd_data : 8'd0;
`ifdef CONV_SEQ_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: a cycle-indexed frame-schedule model checks every output
// each cycle, plus fixed-time expectations for the directed scenarios and a 1-line frame.
module tb_conv_frame_sequencer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int GAP = 2;
    localparam int L = W + GAP;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    logic a_start, a_busy, a_done, a_tmo, a_rd_en, a_fs, a_ls, a_fe, a_ena, a_fp_valid;
    logic [159:0] a_result, a_fp_out;
    logic [3:0] a_addr;
    logic [7:0] a_mem_q, a_ima;
    logic b_start, b_busy, b_done, b_tmo, b_rd_en, b_fs, b_ls, b_fe, b_ena, b_fp_valid;
    logic [159:0] b_result, b_fp_out;
    logic [1:0] b_addr;
    logic [7:0] b_mem_q, b_ima;

    logic [7:0] mem [0:15];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int n_done_a = 0;

    conv_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(4), .LINE_GAP(GAP), .OUT_W(160),
                           .TIMEOUT(TMO)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .result(a_result), .timeout_err(a_tmo), .mem_rd_en(a_rd_en), .mem_addr(a_addr),
        .mem_rd_data(a_mem_q), .frame_start(a_fs), .line_start(a_ls), .frame_end(a_fe),
        .ena(a_ena), .ima(a_ima), .fp_valid(a_fp_valid), .fp_out(a_fp_out));

    conv_frame_sequencer #(.IMG_W(4), .IMG_H(1), .ADDR_W(2), .LINE_GAP(0), .OUT_W(160),
                           .TIMEOUT(TMO)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .result(b_result), .timeout_err(b_tmo), .mem_rd_en(b_rd_en), .mem_addr(b_addr),
        .mem_rd_data(b_mem_q), .frame_start(b_fs), .line_start(b_ls), .frame_end(b_fe),
        .ena(b_ena), .ima(b_ima), .fp_valid(b_fp_valid), .fp_out(b_fp_out));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Image buffer with registered read port; garbage when not read.
    always @(posedge clk) begin
        a_mem_q <= a_rd_en ? mem[a_addr] : 8'($urandom);
        b_mem_q <= b_rd_en ? mem[{2'b00, b_addr}] : 8'($urandom);
    end

    always @(negedge clk) if (a_done) n_done_a++;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic to_cycle(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pixel index read d cycles after the first read of a frame, if any.
    function automatic bit px_at(input int d, output int p);
        int r, c;
        p = 0;
        if (d < 0) return 1'b0;
        r = d / L;
        c = d % L;
        p = r * W + c;
        return (r < H) && (c < W);
    endfunction

    // Model: a frame accepted at cycle T reads pixel (r,c) at T+1+r*L+c, streams it one
    // cycle later, enters WAIT at T+2+(H-1)*L+W, and completes the cycle after fp_valid.
    bit m_run = 1'b0;
    int m_T = 0, m_D = -1, m_Wc = 0;
    bit m_pend_tmo = 1'b0;
    logic [159:0] m_result = '0, m_pend = '0;
    logic e_busy, e_done, e_tmo, e_rd, e_ena;
    int p_rd, p_ena;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (m_run && cyc == m_D) m_result = m_pend;
            e_busy = m_run && cyc > m_T && cyc != m_D;
            e_done = m_run && cyc == m_D;
            e_tmo  = e_done && m_pend_tmo;
            e_rd   = m_run && px_at(cyc - m_T - 1, p_rd);
            e_ena  = m_run && px_at(cyc - m_T - 2, p_ena);
            chk("busy", 160'(a_busy), 160'(e_busy));
            chk("done", 160'(a_done), 160'(e_done));
            chk("timeout_err", 160'(a_tmo), 160'(e_tmo));
            chk("result", a_result, m_result);
            chk("mem_rd_en", 160'(a_rd_en), 160'(e_rd));
            if (e_rd) chk("mem_addr", 160'(a_addr), 160'(p_rd));
            chk("ena", 160'(a_ena), 160'(e_ena));
            if (e_ena) chk("ima", 160'(a_ima), 160'(mem[p_ena]));
            chk("line_start", 160'(a_ls), 160'(e_ena && (p_ena % W) == 0));
            chk("frame_start", 160'(a_fs), 160'(e_ena && p_ena == 0));
            chk("frame_end", 160'(a_fe), 160'(e_ena && p_ena == W * H - 1));
            if (rst) begin
                m_run = 1'b0;
                m_D = -1;
                m_result = '0;
            end else begin
                if (m_run && m_D < 0 && cyc >= m_Wc) begin
                    if (a_fp_valid) begin
                        m_D = cyc + 1;
                        m_pend = a_fp_out;
                        m_pend_tmo = 1'b0;
                    end
`ifdef CONV_SEQ_TIMEOUT_EN
                    else if (cyc == m_Wc + TMO - 1) begin
                        m_D = cyc + 1;
                        m_pend = '0;
                        m_pend_tmo = 1'b1;
                    end
`endif
                end
                if ((!m_run || cyc == m_D) && a_start) begin
                    m_run = 1'b1;
                    m_T = cyc;
                    m_D = -1;
                    m_Wc = cyc + 2 + (H - 1) * L + W;
                end else if (m_run && cyc == m_D) begin
                    m_run = 1'b0;
                end
            end
        end
    end

    int base;

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_fp_valid = 1'b0; a_fp_out = '0;
        b_start = 1'b0; b_fp_valid = 1'b0; b_fp_out = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);

        // Reset state
        to_cycle(2); @(negedge clk);
        chk("rst_busy", 160'(a_busy), 0);
        chk("rst_result", a_result, 0);
        chk("rst_rd_en", 160'(a_rd_en), 0);
        chk("rst_ena", 160'(a_ena), 0);
        chk("rst_b_busy", 160'(b_busy), 0);
        to_cycle(3); rst = 1'b0;

        // Frame at T=5 with mem = addr
        to_cycle(5); a_start = 1'b1;
        to_cycle(6); a_start = 1'b0;
        to_cycle(7); @(negedge clk);
        chk("t1_first_ena", 160'(a_ena), 1);
        chk("t1_first_ima", 160'(a_ima), 0);
        chk("t1_first_fs", 160'(a_fs), 1);
        chk("t1_first_ls", 160'(a_ls), 1);
        to_cycle(11); @(negedge clk);
        chk("t1_gap_ena", 160'(a_ena), 0);
        to_cycle(13); @(negedge clk);
        chk("t1_line1_ima", 160'(a_ima), 4);
        chk("t1_line1_ls", 160'(a_ls), 1);
        to_cycle(22); @(negedge clk);
        chk("t1_last_ima", 160'(a_ima), 11);
        chk("t1_last_fe", 160'(a_fe), 1);
        to_cycle(23); @(negedge clk);
        chk("t1_wait_ena", 160'(a_ena), 0);
        chk("t1_wait_busy", 160'(a_busy), 1);
        to_cycle(25); a_fp_valid = 1'b1; a_fp_out = 160'hA5;
        to_cycle(26); a_fp_valid = 1'b0; @(negedge clk);
        chk("t2_done", 160'(a_done), 1);
        chk("t2_busy", 160'(a_busy), 0);
        chk("t2_result", a_result, 160'hA5);
        to_cycle(27); @(negedge clk);
        chk("t2_done_once", 160'(a_done), 0);

        // Start re-pulsed during READ and WAIT
        to_cycle(30); a_start = 1'b1; base = n_done_a;
        to_cycle(31); a_start = 1'b0;
        to_cycle(33); a_start = 1'b1;
        to_cycle(34); a_start = 1'b0; @(negedge clk);
        chk("t3_addr", 160'(a_addr), 3);
        to_cycle(49); a_start = 1'b1;
        to_cycle(50); a_start = 1'b0;
        to_cycle(55); a_fp_valid = 1'b1; a_fp_out = 160'h1_2345_6789_ABCD;
        to_cycle(56); a_fp_valid = 1'b0;
        to_cycle(60); @(negedge clk);
        chk("t3_done_count", 160'(n_done_a - base), 1);
        chk("t3_idle", 160'(a_busy), 0);

        // Reset at the 6th pixel, then replay
        to_cycle(62); a_start = 1'b1;
        to_cycle(63); a_start = 1'b0;
        to_cycle(71); rst = 1'b1; @(negedge clk);
        chk("t4_px6_ima", 160'(a_ima), 5);
        to_cycle(72); rst = 1'b0; @(negedge clk);
        chk("t4_busy", 160'(a_busy), 0);
        chk("t4_ena", 160'(a_ena), 0);
        chk("t4_result", a_result, 0);
        chk("t4_done", 160'(a_done), 0);
        to_cycle(74); a_start = 1'b1;
        to_cycle(75); a_start = 1'b0; @(negedge clk);
        chk("t4_replay_rd", 160'(a_rd_en), 1);
        chk("t4_replay_addr", 160'(a_addr), 0);
        to_cycle(95); a_fp_valid = 1'b1; a_fp_out = 160'hDEAD_BEEF_CAFE;
        to_cycle(96); a_fp_valid = 1'b0; @(negedge clk);
        chk("t4_done", 160'(a_done), 1);

        // No fp_valid: WAIT entered at 118
        to_cycle(100); a_start = 1'b1;
        to_cycle(101); a_start = 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
        to_cycle(133); @(negedge clk);
        chk("t5_pre_done", 160'(a_done), 0);
        to_cycle(134); @(negedge clk);
        chk("t5_done", 160'(a_done), 1);
        chk("t5_tmo", 160'(a_tmo), 1);
        chk("t5_result", a_result, 0);
        chk("t5_busy", 160'(a_busy), 0);
`else
        to_cycle(219); @(negedge clk);
        chk("t5_busy_hold", 160'(a_busy), 1);
        chk("t5_no_done", 160'(a_done), 0);
        to_cycle(220); a_fp_valid = 1'b1; a_fp_out = 160'h77;
        to_cycle(221); a_fp_valid = 1'b0; @(negedge clk);
        chk("t5_done", 160'(a_done), 1);
        chk("t5_tmo", 160'(a_tmo), 0);
`endif

        // Single 4-pixel line, no gaps
        to_cycle(230); b_start = 1'b1;
        to_cycle(231); b_start = 1'b0; @(negedge clk);
        chk("t6_rd", 160'(b_rd_en), 1);
        chk("t6_addr0", 160'(b_addr), 0);
        for (int k = 232; k <= 235; k++) begin
            to_cycle(k); @(negedge clk);
            chk("t6_ena", 160'(b_ena), 1);
            chk("t6_ima", 160'(b_ima), 160'(k - 232));
            chk("t6_ls", 160'(b_ls), 160'(k == 232));
            chk("t6_fs", 160'(b_fs), 160'(k == 232));
            chk("t6_fe", 160'(b_fe), 160'(k == 235));
        end
        to_cycle(236); @(negedge clk);
        chk("t6_ena_off", 160'(b_ena), 0);
        chk("t6_busy", 160'(b_busy), 1);
        to_cycle(237); b_fp_valid = 1'b1; b_fp_out = 160'h5A;
        to_cycle(238); b_fp_valid = 1'b0; @(negedge clk);
        chk("t6_done", 160'(b_done), 1);
        chk("t6_result", b_result, 160'h5A);
        chk("t6_idle", 160'(b_busy), 0);

        // Random traffic against the model
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        for (int k = 240; k < 840; k++) begin
            to_cycle(k);
            a_start    = ($urandom_range(0, 9) == 0);
            a_fp_valid = ($urandom_range(0, 4) == 0);
            a_fp_out   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rst        = ($urandom_range(0, 299) == 0);
        end
        to_cycle(840);
        a_start = 1'b0; a_fp_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
